// File: rtl/serial_negate_scheduler.sv
// Rotating-priority arbiter in front of one shared bit-serial two's-complement negator.
// Grant in IDLE, WIDTH SHIFT cycles, then DONE holds the tagged result until it is accepted.
module serial_negate_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, id, pick, ptr_nxt, scan_idx;
  logic             pick_vld, take;
  logic [WIDTH-1:0] shreg, res, res_nxt, operand;
  logic [CW-1:0]    bit_cnt;
  logic             seen_one, out_bit, last_bit;

  // Scan ptr, ptr+1, ... wrapping; the first set request wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % NREQ);
      if (!pick_vld && req[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDW'(i)) operand = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Reset overrides a coincident request so nothing is granted while clearing.
  assign take    = (state == IDLE) && pick_vld && !reset;
  assign grant   = take ? (NREQ'(1) << pick) : '0;
  assign ptr_nxt = (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;

  // Serial negate: copy bits up to and including the first 1, invert the rest.
  assign out_bit  = shreg[0] ^ seen_one;
  assign res_nxt  = {out_bit, res[WIDTH-1:1]};
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      id       <= '0;
      shreg    <= '0;
      res      <= '0;
      bit_cnt  <= '0;
      seen_one <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (take) begin
            shreg    <= operand;
            id       <= pick;
            ptr      <= ptr_nxt;
            bit_cnt  <= '0;
            seen_one <= 1'b0;
            res      <= '0;
          end
        end
        SHIFT: begin
          seen_one <= seen_one | shreg[0];
          res      <= res_nxt;
          shreg    <= shreg >> 1;
          bit_cnt  <= bit_cnt + 1'b1;
          if (last_bit) begin
            rsp_data <= res_nxt;
            rsp_id   <= id;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/serial_negate_scheduler.md
# serial_negate_scheduler

Shares one bit-serial two's-complement engine among NREQ requesters. A rotating-priority arbiter picks one pending request and latches its WIDTH-bit operand. The operand is streamed LSB-first through the internal serial negator, one bit per cycle. The negated word is returned on a valid/ready response port tagged with the requester ID. The block sits between the per-channel front ends and the shared arithmetic resource.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits (2..16)
- IDW, $clog2(NREQ), width of requester ID
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- req  input  NREQ  per-requester request, level, held until granted
- req_data  input  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]
- grant  output  NREQ  one-hot, combinational, high for exactly the cycle the operand is sampled
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  two's complement of the granted operand, mod 2^WIDTH
- rsp_id  output  IDW  index of requester that owns rsp_data
- busy  output  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if req != 0, pick the first set bit scanning ptr, ptr+1, … wrapping mod NREQ.
  - Assert grant[i]; latch req_data slice i into shreg and i into id.
  - Set ptr <= (i+1) mod NREQ; clear bit_cnt, seen_one and res; go to SHIFT.
  - If req == 0, stay in IDLE with grant = 0.
- SHIFT, each cycle:
  - b = shreg[0]; out = b XOR seen_one; seen_one <= seen_one OR b.
  - res <= {out, res[WIDTH-1:1]}; shreg >>= 1; bit_cnt++.
  - In the cycle with bit_cnt == WIDTH-1: load rsp_data with the final word and rsp_id with id; go to DONE.
- DONE: rsp_valid = 1; rsp_data and rsp_id held stable. On rsp_valid & rsp_ready, go to IDLE.
- grant is never asserted outside IDLE. Requests arriving during SHIFT/DONE wait and are not lost, since req is level.
- Arithmetic: result = (2^WIDTH − operand) mod 2^WIDTH.
  - 0 → 0.
  - Most-negative value (e.g. 0x80) → itself; no overflow flag.
- A requester keeping req high after its grant is re-eligible only after the others at higher rotating priority are served.

## Timing
- Reset values: state IDLE, ptr 0, grant 0, rsp_valid 0, rsp_data 0, rsp_id 0, busy 0, internal registers 0.
- Grant in cycle T (IDLE).
  - SHIFT occupies T+1 .. T+WIDTH.
  - rsp_valid is high from T+WIDTH+1.
- With rsp_ready high at T+WIDTH+1: IDLE at T+WIDTH+2, and the next grant can occur that same cycle. Peak throughput is one operation per WIDTH+2 cycles.
- Backpressure: rsp_valid stays high and rsp_data/rsp_id stay frozen until the accepting cycle; no new grant in the meantime.
- rsp_ready while rsp_valid is low is ignored.
- Reset asserted in any state, including mid-SHIFT or in DONE: the in-flight operation is discarded with no response. ptr returns to 0. All outputs take reset values in the following cycle.
- Reset and req asserted together: reset wins, no grant.

## Test plan
- Reset: hold reset 3 cycles with req=4'b1111 → grant=0, rsp_valid=0, rsp_data=0, busy=0 throughout.
- Single op: req[1]=1, slice1=0x05, rsp_ready=1 → grant=4'b0010 for 1 cycle at T; rsp_valid at T+9 with rsp_data=0xFB, rsp_id=1; busy low at T+10.
- Edge values, one after another from requester 0: 0x00→0x00, 0x01→0xFF, 0x80→0x80, 0xFF→0x01, 0x7F→0x81.
- Round robin: req=4'b1111 held, data i=0x10+i, rsp_ready=1 →
  - grants in order 0,1,2,3,0, spaced 10 cycles apart;
  - results 0xF0, 0xEF, 0xEE, 0xED with matching rsp_id.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises → rsp_valid, rsp_data, rsp_id stable; grant stays 0 even with req pending; IDLE the cycle after rsp_ready goes high.
- Reset mid-op: assert reset at T+4 during SHIFT → no rsp_valid. Then a new req[2] gets grant[2] (ptr back to 0, scanning from 0), and its result is correct.
